// File: rtl/siso_sched_pkg.sv
// rtl/siso_sched_pkg.sv - shared types, defaults and round-robin pick helper for siso_tx_scheduler
package siso_sched_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N_REQ = 4;
    localparam int MAX_REQ       = 8;

    typedef struct packed {
        logic       any;
        logic [2:0] idx;
    } rr_pick_t;

    // Scan ptr, ptr+1, ... (mod n) and return the first set index; ptr must be < n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n);
        rr_pick_t r;
        int       j;
        r.any = 1'b0;
        r.idx = 3'd0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) begin
                j = j - n;
            end
            if (k < n && !r.any && valid[j[2:0]]) begin
                r.any = 1'b1;
                r.idx = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/siso_tx_scheduler_arbiter.sv
// rtl/siso_tx_scheduler_arbiter.sv - combinational round-robin arbiter with one-hot grant
module rr_arbiter
    import siso_sched_pkg::*;
#(
    parameter  int N_REQ = DEFAULT_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req_i), 3'(ptr_i), N_REQ);
        idx_o = pick.idx[IDX_W-1:0];
        any_o = pick.any;
        gnt_o = '0;
        if (en_i && pick.any) begin
            gnt_o[pick.idx[IDX_W-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/siso_tx_scheduler.sv
// rtl/siso_tx_scheduler.sv - round-robin scheduler feeding one LSB-first serial shift path
module siso_tx_scheduler
    import siso_sched_pkg::*;
#(
    parameter  int N_REQ = DEFAULT_N_REQ,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = $clog2(N_REQ),
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   sout,
    output logic                   sout_valid,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   word_done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;

    logic               last_bit;
    logic               accept_ok;
    logic               accept;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    assign last_bit  = (state_q == S_SHIFT) && (bit_cnt_q == CNT_W'(WIDTH - 1));
    assign accept_ok = (state_q == S_IDLE) || last_bit;

    // Ready is masked during reset so the async clear never exposes a stray accept strobe.
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (accept_ok && !rst),
        .gnt_o (req_ready),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign accept     = |(req_valid & req_ready);
    assign sout       = (state_q == S_SHIFT) && shreg_q[0];
    assign sout_valid = (state_q == S_SHIFT);
    assign word_done  = last_bit;
    assign grant_id   = grant_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        if (accept) begin
            state_d   = S_SHIFT;
            shreg_d   = req_data[pick_idx*WIDTH +: WIDTH];
            bit_cnt_d = '0;
            grant_d   = pick_idx;
            rr_ptr_d  = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end else if (state_q == S_SHIFT) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            if (last_bit) begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
        end
    end

endmodule

// File: tb/tb_siso_tx_scheduler.sv
// tb/tb_siso_tx_scheduler.sv - scoreboard bench for siso_tx_scheduler with randomized requesters
module tb_siso_tx_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           sout;
    logic           sout_valid;
    logic [1:0]     grant_id;
    logic           word_done;

    siso_tx_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .grant_id   (grant_id),
        .word_done  (word_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   id;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] pend[N][$];
    int           checks   = 0;
    int           failures = 0;
    int           m_ptr    = 0;
    int           m_left   = 0;
    logic [N-1:0] acc_vec  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit busy();
        bit b = (m_left > 0);
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic push(input int i, input logic [W-1:0] w);
        pend[i].push_back(w);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy() && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (busy()) begin
            failures++;
            $display("FAIL drain_timeout actual=busy expected=idle time=%0t", $time);
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor/model: m_left counts serial bits still owed for the current word.
    initial begin : monitor
        int           win;
        int           j;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] word;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_sout", sout, 0);
                chk("rst_sout_valid", sout_valid, 0);
                chk("rst_word_done", word_done, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_grant_id", grant_id, 0);
                m_ptr   = 0;
                m_left  = 0;
                acc_vec = '0;
                sb.delete();
            end else begin
                chk("sout_valid", sout_valid, (m_left > 0));
                chk("word_done", word_done, (m_left == 1));
                if (m_left > 0 && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sout_bit", sout, e.b);
                    chk("grant_id", grant_id, e.id);
                end else begin
                    chk("sout_idle", sout, 0);
                end
                win = -1;
                if (m_left <= 1) begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_ptr + k) % N;
                        if (win < 0 && req_valid[j]) win = j;
                    end
                end
                exp_rdy = '0;
                if (win >= 0) exp_rdy[win] = 1'b1;
                chk("req_ready", req_ready, exp_rdy);
                acc_vec = exp_rdy;
                if (win >= 0) begin
                    word = req_data[win*W +: W];
                    for (int b = 0; b < W; b++) sb.push_back('{word[b], win});
                    m_ptr  = (win + 1) % N;
                    m_left = W;
                end else if (m_left > 0) begin
                    m_left--;
                end
            end
        end
    end

    // Requester driver: hold valid and data steady until the model-observed accept.
    initial begin : driver
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_vec[i] && pend[i].size() > 0) void'(pend[i].pop_front());
                req_valid[i] = (pend[i].size() > 0);
                req_data[i*W +: W] = (pend[i].size() > 0) ? pend[i][0] : W'($urandom);
            end
        end
    end

    initial begin : main
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        push(0, 8'h95);
        wait_idle();

        push(1, 8'hFF);
        push(1, 8'h00);
        wait_idle();

        push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
        wait_idle();

        push(1, 8'h6B);
        wait_idle();
        push(0, 8'hC3);
        push(3, 8'h3C);
        wait_idle();

        push(0, 8'hD2);
        repeat (5) @(posedge clk);
        #2 push(2, 8'h4E);
        wait_idle();

        push(0, 8'hA5);
        n = 0;
        while (!sout_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset_setup_valid", sout_valid, 1);
        push(3, 8'h5A);
        push(0, 8'h81);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sout", sout, 0);
        chk("async_rst_sout_valid", sout_valid, 0);
        chk("async_rst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_idle();

        repeat (3000) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(0, N - 1);
                if (pend[n].size() < 3) push(n, W'($urandom));
            end
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/siso_tx_scheduler.md
# siso_tx_scheduler

Round-robin scheduler that shares one 8-bit serial-out shift path between N parallel requesters. It accepts a word from the winning requester through a valid/ready handshake and shifts it out LSB-first, one bit per clock. Transfers can run back to back with no idle bit between words. It sits in front of the serial link, alongside the SISO register family in the level-0 serial blocks.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, word width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  N_REQ  per-requester word available
- req_data  in  N_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot accept strobe (combinational)
- sout  out  1  serial data, LSB first
- sout_valid  out  1  high while sout carries a valid bit
- grant_id  out  $clog2(N_REQ)  index of the requester whose word is shifting
- word_done  out  1  high during the last bit of each word

## Operation
- States are IDLE and SHIFT. Registers:
  - shreg[WIDTH]
  - bit_cnt[$clog2(WIDTH)]
  - rr_ptr, the highest-priority index
  - grant_id
- Accept window: `accept_ok = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1)`.
- Arbitration:
  - When accept_ok and any req_valid, exactly one req_ready[w] is high.
  - w is the first valid index found scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - All other req_ready bits are 0.
  - When accept_ok is low, all req_ready bits are 0.
- On the edge where req_valid[w] && req_ready[w]:
  - shreg <= word w
  - bit_cnt <= 0
  - grant_id <= w
  - rr_ptr <= (w+1) mod N_REQ
  - state <= SHIFT
- In SHIFT:
  - sout = shreg[0] and sout_valid = 1.
  - Each edge shifts shreg right and increments bit_cnt.
- At bit_cnt==WIDTH-1:
  - word_done = 1.
  - If a new word is accepted on this edge, state stays SHIFT and the next word's bit 0 follows with no gap.
  - Otherwise state goes to IDLE.
- In IDLE: sout = 0, sout_valid = 0, word_done = 0. grant_id holds its last value.
- Requesters hold req_valid and data stable until accepted. The block does not sample req_data outside an accept edge.
- A valid that drops before acceptance is simply not granted; no error is raised.
- Reset, including mid-word:
  - state = IDLE, sout = 0, sout_valid = 0, word_done = 0, req_ready = 0
  - grant_id = 0, rr_ptr = 0, bit_cnt = 0, shreg = 0
  - The partial word is discarded and is not resent.

## Timing
- Latency: with an accept at edge k, bit 0 appears on sout in cycle k+1 and bit WIDTH-1 in cycle k+WIDTH.
- Throughput: 1 bit/clk sustained, i.e. WIDTH cycles per word when requests are continuous.
- From IDLE, a single request costs WIDTH+1 cycles of its valid being high: the accept cycle plus WIDTH shift cycles. The ready strobe is in the accept cycle.
- req_ready depends combinationally on req_valid, state, bit_cnt and rr_ptr. There is no path from req_data.
- sout, sout_valid and word_done are decoded from registers only (no input-to-output path).
- Simultaneous requests: the round-robin pointer guarantees each continuously-valid requester is granted within N_REQ words.

## Structure
- Package siso_sched_pkg holds:
  - the state enum (S_IDLE, S_SHIFT)
  - localparam defaults (WIDTH = 8, N_REQ = 4)
  - a function rr_pick(valid, ptr) returning the winner index and an any-valid flag.
- One sub-module is natural: rr_arbiter. It is combinational, takes req, ptr and enable, and produces a one-hot grant plus the index.
- The top-level holds the FSM, the counter, the shifter and the pointer update.

## Test plan
- **Reset:** assert rst mid-word (bit 3 of 0xA5) → sout = 0, sout_valid = 0 and req_ready = 0 immediately, without waiting for a clock edge. After release, the next grant goes to requester 0.
- **Single word:** requester 0 sends 0x95 from IDLE → req_ready[0] pulses for 1 cycle. Next 8 cycles sout = 1,0,1,0,1,0,0,1 with sout_valid = 1. word_done is high on the 8th cycle only. Then IDLE.
- **Back-to-back:** requester 1 holds valid with 0xFF, then 0x00 → 16 consecutive sout_valid cycles with no gap. The second req_ready pulse coincides with word_done.
- **Round-robin:** all 4 valid continuously with words 0x11, 0x22, 0x33, 0x44 → grant_id sequence 0,1,2,3,0. Each requester is granted exactly once per 4 words.
- **Pointer skip:** after a grant to 1, only requesters 0 and 3 are valid → 3 is granted first, then 0.
- **Late valid:** requester 2 asserts valid during bit 4 of another word → no ready until the last-bit cycle. It is then granted with zero gap.
